conv_loop_ctrl: RTL and testbench
=================================

CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

Interface
REQ-001 The block SHALL have parameter CONV_DIM_IMG, default 32: input image width and height.
REQ-002 The block SHALL have parameter CONV_DIM_KERNEL, default 5: kernel width and height (K).
REQ-003 The block SHALL have parameter CONV_DIM_CH, default 3: input channels (C).
REQ-004 The block SHALL have parameter CONV_OUT_CH, default 32: output channels.
REQ-005 The block SHALL have parameter CONV_DIM_OUT, default 32: output width and height (D).
REQ-006 The block SHALL have parameter STRIDE, default 1, and parameter PADDING, default 2.
REQ-007 The block SHALL have parameter SAVE_LAT, default 2, range 1..8: cycles from the last tap of a pixel to its en_save.
REQ-008 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 The block SHALL have port start, input, 1 bit: request one full convolution pass.
REQ-011 The block SHALL have port stall, input, 1 bit: freeze tap issue for this cycle.
REQ-012 The block SHALL have ports i, j, k, m, n, l, each an 8-bit output: out-channel, out-row, out-col, kernel-row, kernel-col and in-channel indices.
REQ-013 The block SHALL have ports enable, tap_valid, acc_clr, en_save, busy and done, each a 1-bit output: tap issue, tap inside image, first tap of pixel, pixel store strobe, pass active, pass complete.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-015 In IDLE, start=1 SHALL clear all counters and move to RUN on the next cycle; start SHALL be ignored in every other state.
REQ-016 enable SHALL equal (state==RUN && !stall), combinationally; a cycle with enable=1 is one tap.
REQ-017 Counters SHALL advance only on tap cycles and hold otherwise, including during stall.
REQ-018 Loop nest, innermost first: l 0..C-1, n 0..K-1, m 0..K-1, k 0..D-1, j 0..D-1, i 0..CONV_OUT_CH-1; each counter wraps to 0 and carries into the next outer counter.
REQ-019 The last tap SHALL be the tap with all counters at their maximum; after it the FSM SHALL enter DRAIN and counters SHALL hold their maximum values.
REQ-020 Indices i..l SHALL be the registered counter values, valid on every tap cycle.
REQ-021 tap_valid SHALL be 1 when row = STRIDE*j+m and col = STRIDE*k+n satisfy PADDING <= row < CONV_DIM_IMG+PADDING and the same holds for col.
REQ-022 tap_valid SHALL be computed at 16-bit unsigned width with no negative intermediates, and SHALL be 0 outside tap cycles.
REQ-023 acc_clr SHALL be 1 on tap cycles where m=n=l=0.
REQ-024 last_tap SHALL be the internal flag (tap cycle with m=K-1, n=K-1, l=C-1); it SHALL feed a SAVE_LAT-deep shift register clocked every cycle, independent of stall.
REQ-025 en_save SHALL be the shift register output: exactly one pulse per output pixel, SAVE_LAT cycles after that pixel's last tap.
REQ-026 DRAIN SHALL last exactly SAVE_LAT cycles, then move to DONE.
REQ-027 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-028 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-029 stall in IDLE, DRAIN or DONE SHALL have no effect; stall on the last tap cycle SHALL delay the DRAIN entry.

Reset
REQ-030 reset=1 SHALL force IDLE in all cases; reset SHALL take priority over start.
REQ-031 While reset=1, counters, the shift register and all outputs SHALL be 0.
REQ-032 reset asserted during RUN or DRAIN SHALL abort the pass with no further en_save and no done pulse.

Verification
Common configuration: IMG=4, K=3, C=2, OUT_CH=2, D=4, STRIDE=1, PADDING=1, SAVE_LAT=2.
REQ-033 The bench SHALL check: start pulse with no stall -> enable is 1 for exactly 576 consecutive cycles; 32 en_save pulses; done is 1 exactly 3 cycles after the last enable.
REQ-034 The bench SHALL check: same pass -> the first tap (j=k=m=n=0) has tap_valid=0; tap j=k=0, m=n=1 has tap_valid=1; per pixel (0,0), 8 of 18 taps have tap_valid=1.
REQ-035 The bench SHALL check: stall=1 for 5 cycles mid-pixel -> indices frozen during the stall; total enable cycles still 576; done delayed by exactly 5 cycles.
REQ-036 The bench SHALL check: stall=1 in the cycle right after a last tap -> en_save still occurs exactly 2 cycles after that tap.
REQ-037 The bench SHALL check: start asserted in RUN, DRAIN and DONE -> ignored, the pass is unchanged, and exactly one done pulse occurs.
REQ-038 The bench SHALL check: reset at tap 100 -> the next cycle has busy=0 and all outputs 0; a new start then gives a full, correct 576-tap pass.

Source files
------------

// File: rtl/conv_loop_ctrl.sv
// Purpose : sequences the six-deep convolution loop nest (out-ch, out-row, out-col,
//           kernel-row, kernel-col, in-ch) and issues one tap per enabled cycle.
// Latency : first tap the cycle after start; en_save SAVE_LAT cycles after a pixel's last tap.
// Backpressure: stall freezes tap issue and counters; the save pipeline keeps moving.
// Ports   : clk/reset (sync, active-high), start, stall -> indices i..l, enable,
//           tap_valid, acc_clr, en_save, busy, done.
module conv_loop_ctrl #(
    parameter int CONV_DIM_IMG    = 32,
    parameter int CONV_DIM_KERNEL = 5,
    parameter int CONV_DIM_CH     = 3,
    parameter int CONV_OUT_CH     = 32,
    parameter int CONV_DIM_OUT    = 32,
    parameter int STRIDE          = 1,
    parameter int PADDING         = 2,
    parameter int SAVE_LAT        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] i,
    output logic [7:0] j,
    output logic [7:0] k,
    output logic [7:0] m,
    output logic [7:0] n,
    output logic [7:0] l,
    output logic       enable,
    output logic       tap_valid,
    output logic       acc_clr,
    output logic       en_save,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0]  L_MAX      = 8'(CONV_DIM_CH - 1);
    localparam logic [7:0]  KER_MAX    = 8'(CONV_DIM_KERNEL - 1);
    localparam logic [7:0]  OUT_MAX    = 8'(CONV_DIM_OUT - 1);
    localparam logic [7:0]  I_MAX      = 8'(CONV_OUT_CH - 1);
    localparam logic [3:0]  DRAIN_LAST = 4'(SAVE_LAT - 1);
    localparam logic [15:0] STR16      = 16'(STRIDE);
    localparam logic [15:0] PAD16      = 16'(PADDING);
    localparam logic [15:0] HI16       = 16'(CONV_DIM_IMG + PADDING);

    state_t state, state_nxt;

    logic [7:0]          i_q, j_q, k_q, m_q, n_q, l_q;
    logic [3:0]          drain_cnt;
    logic [SAVE_LAT-1:0] save_sr;
    logic                tap, last_tap, final_tap;
    logic                l_wrap, n_wrap, m_wrap, k_wrap, j_wrap, i_wrap;
    logic [15:0]         row, col;

    // Reset gates the tap strobe combinationally so nothing is issued in the
    // cycle reset is applied, even though the state register is still RUN.
    assign tap = (state == RUN) && !stall && !reset;

    // Carry chain: each wrap means "this and every inner counter is at max".
    assign l_wrap = (l_q == L_MAX);
    assign n_wrap = l_wrap && (n_q == KER_MAX);
    assign m_wrap = n_wrap && (m_q == KER_MAX);
    assign k_wrap = m_wrap && (k_q == OUT_MAX);
    assign j_wrap = k_wrap && (j_q == OUT_MAX);
    assign i_wrap = j_wrap && (i_q == I_MAX);

    assign last_tap  = tap && m_wrap;
    assign final_tap = tap && i_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters hold at their maxima after the final tap until the next start.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            i_q <= '0; j_q <= '0; k_q <= '0;
            m_q <= '0; n_q <= '0; l_q <= '0;
        end else if (tap && !i_wrap) begin
            l_q <= l_wrap ? '0 : l_q + 8'd1;
            if (l_wrap) n_q <= n_wrap ? '0 : n_q + 8'd1;
            if (n_wrap) m_q <= m_wrap ? '0 : m_q + 8'd1;
            if (m_wrap) k_q <= k_wrap ? '0 : k_q + 8'd1;
            if (k_wrap) j_q <= j_wrap ? '0 : j_q + 8'd1;
            if (j_wrap) i_q <= i_q + 8'd1;
        end
    end

    // Save pipeline runs every cycle, independent of stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            save_sr <= '0;
        end else begin
            save_sr[0] <= last_tap;
            for (int s = 1; s < SAVE_LAT; s++) begin
                save_sr[s] <= save_sr[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        i = '0; j = '0; k = '0; m = '0; n = '0; l = '0;
        enable    = 1'b0;
        tap_valid = 1'b0;
        acc_clr   = 1'b0;
        en_save   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        // Unsigned image coordinates include the padding offset, so the
        // bounds test never needs a negative intermediate.
        row = STR16 * {8'h00, j_q} + {8'h00, m_q};
        col = STR16 * {8'h00, k_q} + {8'h00, n_q};

        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (final_tap) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (!reset) begin
            i = i_q; j = j_q; k = k_q; m = m_q; n = n_q; l = l_q;
            enable    = tap;
            tap_valid = tap && (row >= PAD16) && (row < HI16)
                            && (col >= PAD16) && (col < HI16);
            acc_clr   = tap && (m_q == 8'd0) && (n_q == 8'd0) && (l_q == 8'd0);
            en_save   = save_sr[SAVE_LAT-1];
            busy      = (state != IDLE);
            done      = (state == DONE);
        end
    end

endmodule

// File: tb/tb_conv_loop_ctrl.sv
module tb_conv_loop_ctrl;

    localparam int IMG = 4, K = 3, C = 2, OC = 2, D = 4, ST = 1, PAD = 1, SL = 2;
    localparam int NTAP = OC * D * D * K * K * C;  // 576

    logic       clk = 1'b0;
    logic       reset, start, stall;
    logic [7:0] i, j, k, m, n, l;
    logic       enable, tap_valid, acc_clr, en_save, busy, done;

    conv_loop_ctrl #(
        .CONV_DIM_IMG(IMG), .CONV_DIM_KERNEL(K), .CONV_DIM_CH(C),
        .CONV_OUT_CH(OC), .CONV_DIM_OUT(D), .STRIDE(ST), .PADDING(PAD),
        .SAVE_LAT(SL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .i(i), .j(j), .k(k), .m(m), .n(n), .l(l),
        .enable(enable), .tap_valid(tap_valid), .acc_clr(acc_clr),
        .en_save(en_save), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] i, j, k, m, n, l;
        logic       tv, clr, last;
    } tap_t;

    tap_t        tapq[$];
    int          saveq[$];
    int          errors = 0, checks = 0;
    int          cyc = 0;
    int          n_en, first_en, last_en, n_save, n_done, done_cyc;
    logic [17:0] obs_tv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input tap_t t);
        return {14'd0, t.i, t.j, t.k, t.m, t.n, t.l, t.tv, t.clr};
    endfunction

    function automatic logic [63:0] outs();
        return {10'd0, i, j, k, m, n, l, enable, tap_valid, acc_clr, en_save, busy, done};
    endfunction

    // Monitor: pops the expected tap for every enable, expected save cycle for every en_save.
    always @(negedge clk) begin
        tap_t t;
        if (enable === 1'b1) begin
            n_en++;
            if (n_en == 1) first_en = cyc;
            last_en = cyc;
            if (n_en <= 18) obs_tv[n_en-1] = tap_valid;
            if (tapq.size() == 0) begin
                chk("tap_unexpected", 64'd1, 64'd0);
            end else begin
                t = tapq.pop_front();
                chk("tap", {14'd0, i, j, k, m, n, l, tap_valid, acc_clr}, pk(t));
                if (t.last) saveq.push_back(cyc + SL);
            end
        end
        if (en_save === 1'b1) begin
            n_save++;
            if (saveq.size() == 0) chk("en_save_unexpected", 64'd1, 64'd0);
            else chk("en_save_cyc", 64'(cyc), 64'(saveq.pop_front()));
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_stats();
        n_en = 0; first_en = 0; last_en = 0; n_save = 0; n_done = 0; done_cyc = 0;
        obs_tv = '0;
        tapq.delete();
        saveq.delete();
    endtask

    task automatic build_pass();
        tap_t t;
        int   row, col;
        for (int ii = 0; ii < OC; ii++)
        for (int jj = 0; jj < D; jj++)
        for (int kk = 0; kk < D; kk++)
        for (int mm = 0; mm < K; mm++)
        for (int nn = 0; nn < K; nn++)
        for (int ll = 0; ll < C; ll++) begin
            row = ST * jj + mm;
            col = ST * kk + nn;
            t.i = 8'(ii); t.j = 8'(jj); t.k = 8'(kk);
            t.m = 8'(mm); t.n = 8'(nn); t.l = 8'(ll);
            t.tv   = (row >= PAD) && (row < IMG + PAD) && (col >= PAD) && (col < IMG + PAD);
            t.clr  = (mm == 0) && (nn == 0) && (ll == 0);
            t.last = (mm == K - 1) && (nn == K - 1) && (ll == C - 1);
            tapq.push_back(t);
        end
    endtask

    task automatic start_pass(output int s);
        reset_stats();
        build_pass();
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_taps(input int target);
        int b = 0;
        while (n_en < target && b < 2000) begin tick(); b++; end
        if (n_en < target) chk("wait_taps_timeout", 64'(n_en), 64'(target));
    endtask

    task automatic wait_done();
        int b = 0;
        while (n_done < 1 && b < 2000) begin tick(); b++; end
        if (n_done < 1) chk("wait_done_timeout", 64'(n_done), 64'd1);
        tick(); tick();
    endtask

    task automatic check_pass(input string nm, input int s, input int rel);
        chk({nm, "_taps"}, 64'(n_en), 64'(NTAP));
        chk({nm, "_saves"}, 64'(n_save), 64'd32);
        chk({nm, "_dones"}, 64'(n_done), 64'd1);
        chk({nm, "_done_rel_start"}, 64'(done_cyc - s), 64'(rel));
        chk({nm, "_done_after_last_tap"}, 64'(done_cyc - last_en), 64'd3);
        chk({nm, "_tapq_empty"}, 64'(tapq.size()), 64'd0);
        chk({nm, "_saveq_empty"}, 64'(saveq.size()), 64'd0);
        chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int s;
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        reset_stats();
        tick();
        @(negedge clk); chk("reset_outs", outs(), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk); chk("idle_outs", outs(), 64'd0);
        tick();

        // Plain pass: 576 back-to-back taps, done 3 cycles after the last one.
        start_pass(s);
        wait_done();
        check_pass("pass1", s, 579);
        chk("pass1_consecutive", 64'(last_en - first_en), 64'(NTAP - 1));
        chk("pix00_first_tv", 64'(obs_tv[0]), 64'd0);
        chk("pix00_m1n1_tv", 64'(obs_tv[8]), 64'd1);
        chk("pix00_valid_cnt", 64'($countones(obs_tv)), 64'd8);

        // Five-cycle stall in the middle of pixel (0,0): counters sit at tap 5.
        start_pass(s);
        wait_taps(5);
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_enable", 64'(enable), 64'd0);
            chk("stall_idx", {16'd0, i, j, k, m, n, l}, 64'h0000_0000_0000_0201);
            tick();
        end
        stall = 1'b0;
        wait_done();
        check_pass("stall5", s, 584);

        // Stall right after pixel 0's last tap; en_save still two cycles after it.
        start_pass(s);
        wait_taps(18);
        stall = 1'b1;
        @(negedge clk); chk("save_in_stall", 64'(en_save), 64'd0);
        tick();
        stall = 1'b0;
        @(negedge clk); chk("save_after_stall", 64'(en_save), 64'd1);
        wait_done();
        check_pass("stall_after_last", s, 580);

        // start held in RUN, then through DRAIN and DONE: all ignored.
        start_pass(s);
        wait_taps(50);
        start = 1'b1; tick(); start = 1'b0;
        wait_taps(NTAP);
        chk("in_drain_busy", 64'(busy), 64'd1);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (5) tick();
        check_pass("start_ignored", s, 579);

        // Reset at tap 100 aborts the pass; then a fresh full pass.
        start_pass(s);
        wait_taps(100);
        reset = 1'b1;
        @(negedge clk); chk("abort_reset_outs", outs(), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk); chk("abort_next_outs", outs(), 64'd0);
        repeat (10) tick();
        chk("abort_saves", 64'(n_save), 64'd5);
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_saveq", 64'(saveq.size()), 64'd0);
        start_pass(s);
        wait_done();
        check_pass("after_abort", s, 579);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
